// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, and derive
// press/release pulses plus an optional hold-to-repeat pulse per channel.
module key_conditioner #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] rep_en,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] rep_pulse
);

    localparam int DB_W     = $clog2(DB_CYCLES) + 1;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX) + 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [HW-1:0]   DELAY_LOAD  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0]   PERIOD_LOAD = HW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic            act;
        logic            s1_q, s2_q;
        logic            pressed_q, pressed_d;
        logic            press_q, release_q, rep_q;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic [HW-1:0]   hold_cnt_q;
        logic            accept;
        rep_state_e      state_q;

        assign act    = (ACTIVE_LOW != 0) ? ~key_raw[g] : key_raw[g];
        assign accept = (s2_q != pressed_q) && (db_cnt_q == DB_LAST);

        // Any sample matching the current level restarts the stability count.
        always_comb begin
            pressed_d = pressed_q;
            db_cnt_d  = '0;
            if (s2_q != pressed_q) begin
                if (accept) begin
                    pressed_d = ~pressed_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q       <= 1'b0;
                s2_q       <= 1'b0;
                pressed_q  <= 1'b0;
                db_cnt_q   <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                rep_q      <= 1'b0;
                hold_cnt_q <= '0;
                state_q    <= ST_IDLE;
            end else begin
                s1_q      <= act;
                s2_q      <= s1_q;
                pressed_q <= pressed_d;
                db_cnt_q  <= db_cnt_d;
                press_q   <= accept & ~pressed_q;
                release_q <= accept & pressed_q;
                rep_q     <= 1'b0;

                // An accepted release wins over a repeat pulse due in the same cycle.
                if (accept && pressed_q) begin
                    state_q    <= ST_IDLE;
                    hold_cnt_q <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (accept) begin
                                state_q    <= ST_DELAY;
                                hold_cnt_q <= DELAY_LOAD;
                            end
                        end
                        ST_DELAY, ST_REPEAT: begin
                            if (hold_cnt_q == '0) begin
                                rep_q      <= rep_en[g];
                                hold_cnt_q <= PERIOD_LOAD;
                                state_q    <= ST_REPEAT;
                            end else begin
                                hold_cnt_q <= hold_cnt_q - 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= ST_IDLE;
                            hold_cnt_q <= '0;
                        end
                    endcase
                end
            end
        end

        assign pressed[g]       = pressed_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign rep_pulse[g]     = rep_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with N_KEYS=4, active-low keys,
// DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_conditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] rep_en;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] rep_pulse;

    int total = 0;
    int bad   = 0;

    key_conditioner #(
        .N_KEYS(4),
        .ACTIVE_LOW(1),
        .DB_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_raw(key_raw),
        .rep_en(rep_en),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .rep_pulse(rep_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        key_raw = 4'hF;
        rep_en  = 4'h0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_raw = 4'hF;
        rep_en  = 4'h0;
        repeat (3) tick();
        total++;
        if ({pressed, press_pulse, release_pulse, rep_pulse} !== 16'h0) begin
            bad++;
            $display("FAIL reset_low: got %h want 0000", {pressed, press_pulse, release_pulse, rep_pulse});
        end
        reset_n = 1'b1;
        repeat (8) tick();
        total++;
        if ({pressed, press_pulse, release_pulse, rep_pulse} !== 16'h0) begin
            bad++;
            $display("FAIL reset_idle: got %h want 0000", {pressed, press_pulse, release_pulse, rep_pulse});
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_p, exp_pp;
        key_raw[0] = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            tick();
            exp_p  = (j >= 5) ? 4'b0001 : 4'b0000;
            exp_pp = (j == 5) ? 4'b0001 : 4'b0000;
            total++;
            if (pressed !== exp_p) begin
                bad++;
                $display("FAIL clean_pressed edge %0d: got %b want %b", j, pressed, exp_p);
            end
            total++;
            if (press_pulse !== exp_pp) begin
                bad++;
                $display("FAIL clean_press_pulse edge %0d: got %b want %b", j, press_pulse, exp_pp);
            end
            total++;
            if ((release_pulse | rep_pulse) !== 4'b0000) begin
                bad++;
                $display("FAIL clean_other edge %0d: rel %b rep %b want 0000", j, release_pulse, rep_pulse);
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        logic [3:0] exp_p, exp_pp;
        for (int j = 0; j <= 29; j++) begin
            key_raw[1] = (j < 20) ? (((j / 2) % 2) == 1) : 1'b0;
            tick();
            exp_p  = (j >= 25) ? 4'b0010 : 4'b0000;
            exp_pp = (j == 25) ? 4'b0010 : 4'b0000;
            total++;
            if (pressed !== exp_p) begin
                bad++;
                $display("FAIL bounce_pressed edge %0d: got %b want %b", j, pressed, exp_p);
            end
            total++;
            if (press_pulse !== exp_pp) begin
                bad++;
                $display("FAIL bounce_press_pulse edge %0d: got %b want %b", j, press_pulse, exp_pp);
            end
            total++;
            if (release_pulse !== 4'b0000) begin
                bad++;
                $display("FAIL bounce_release edge %0d: got %b want 0000", j, release_pulse);
            end
        end
        settle();
    endtask

    // Key 2 pressed before edge 0 (press_pulse at p=5), released before edge 31,
    // so the release is accepted at p+31 where a repeat would otherwise be due.
    task automatic run_hold(input logic en, input string name);
        logic [3:0] exp_p, exp_pp, exp_rel, exp_rep;
        rep_en[2] = en;
        for (int j = 0; j <= 45; j++) begin
            key_raw[2] = (j >= 31);
            tick();
            exp_p   = (j >= 5 && j < 36) ? 4'b0100 : 4'b0000;
            exp_pp  = (j == 5) ? 4'b0100 : 4'b0000;
            exp_rel = (j == 36) ? 4'b0100 : 4'b0000;
            exp_rep = (en && j >= 15 && j <= 33 && ((j - 15) % 3) == 0) ? 4'b0100 : 4'b0000;
            total++;
            if (pressed !== exp_p) begin
                bad++;
                $display("FAIL %s_pressed edge %0d: got %b want %b", name, j, pressed, exp_p);
            end
            total++;
            if (press_pulse !== exp_pp) begin
                bad++;
                $display("FAIL %s_press_pulse edge %0d: got %b want %b", name, j, press_pulse, exp_pp);
            end
            total++;
            if (release_pulse !== exp_rel) begin
                bad++;
                $display("FAIL %s_release_pulse edge %0d: got %b want %b", name, j, release_pulse, exp_rel);
            end
            total++;
            if (rep_pulse !== exp_rep) begin
                bad++;
                $display("FAIL %s_rep_pulse edge %0d: got %b want %b", name, j, rep_pulse, exp_rep);
            end
        end
        settle();
    endtask

    task automatic test_auto_repeat();
        run_hold(1'b1, "repeat_on");
    endtask

    task automatic test_repeat_disabled();
        run_hold(1'b0, "repeat_off");
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_p, exp_pp, exp_rel;
        key_raw[0] = 1'b0;
        key_raw[3] = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            tick();
            exp_p  = (j >= 5) ? 4'b1001 : 4'b0000;
            exp_pp = (j == 5) ? 4'b1001 : 4'b0000;
            total++;
            if (pressed !== exp_p) begin
                bad++;
                $display("FAIL simul_pressed edge %0d: got %b want %b", j, pressed, exp_p);
            end
            total++;
            if (press_pulse !== exp_pp) begin
                bad++;
                $display("FAIL simul_press_pulse edge %0d: got %b want %b", j, press_pulse, exp_pp);
            end
        end
        key_raw[3] = 1'b1;
        for (int j = 0; j <= 7; j++) begin
            tick();
            exp_p   = (j >= 5) ? 4'b0001 : 4'b1001;
            exp_rel = (j == 5) ? 4'b1000 : 4'b0000;
            total++;
            if (pressed !== exp_p) begin
                bad++;
                $display("FAIL simul_rel_pressed edge %0d: got %b want %b", j, pressed, exp_p);
            end
            total++;
            if (release_pulse !== exp_rel) begin
                bad++;
                $display("FAIL simul_release_pulse edge %0d: got %b want %b", j, release_pulse, exp_rel);
            end
            total++;
            if (press_pulse !== 4'b0000) begin
                bad++;
                $display("FAIL simul_rel_press_pulse edge %0d: got %b want 0000", j, press_pulse);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] exp_p, exp_pp;
        key_raw[0] = 1'b0;
        repeat (8) tick();
        total++;
        if (pressed !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_pre_pressed: got %b want 0001", pressed);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({pressed, press_pulse, release_pulse, rep_pulse} !== 16'h0) begin
            bad++;
            $display("FAIL midrst_async_clear: got %h want 0000", {pressed, press_pulse, release_pulse, rep_pulse});
        end
        repeat (2) tick();
        total++;
        if ({pressed, press_pulse, release_pulse, rep_pulse} !== 16'h0) begin
            bad++;
            $display("FAIL midrst_held_low: got %h want 0000", {pressed, press_pulse, release_pulse, rep_pulse});
        end
        reset_n = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            exp_p  = (j >= 6) ? 4'b0001 : 4'b0000;
            exp_pp = (j == 6) ? 4'b0001 : 4'b0000;
            total++;
            if (pressed !== exp_p) begin
                bad++;
                $display("FAIL midrst_pressed edge %0d: got %b want %b", j, pressed, exp_p);
            end
            total++;
            if (press_pulse !== exp_pp) begin
                bad++;
                $display("FAIL midrst_press_pulse edge %0d: got %b want %b", j, press_pulse, exp_pp);
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_disabled();
        test_simultaneous();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
